// File: rtl/multi_edge_det.sv
// Multi-channel synchronised edge detector with sticky pending flags and an interrupt summary.
// Define EDGE_DET_FILTER_EN to compile in the per-channel glitch filter.
module multi_edge_det #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   sig,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   clr,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   pend,
    output logic           irq,
    output logic [4:0]     idx
);

`ifdef EDGE_DET_FILTER_EN
    localparam int unsigned BlankCycles = SYNC_STAGES + 1 + FILT_CYCLES;
`else
    localparam int unsigned BlankCycles = SYNC_STAGES + 1;
`endif
    localparam int unsigned BlankW = $clog2(BlankCycles + 1);

    logic [N-1:0]      sync_q [SYNC_STAGES];
    logic [N-1:0]      sync_d [SYNC_STAGES];
    logic [N-1:0]      s, det, rise, fall;
    logic [N-1:0]      prev_q, prev_d;
    logic [N-1:0]      pulse_q, pulse_d;
    logic [N-1:0]      pend_q, pend_d;
    logic              irq_q, irq_d;
    logic [4:0]        idx_q, idx_d;
    logic [BlankW-1:0] blank_q, blank_d;
    logic              blank_done;

    always_comb begin
        sync_d[0] = sig;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DET_FILTER_EN
    localparam int unsigned FiltW = $clog2(FILT_CYCLES + 1);

    logic [N-1:0]     filt_q, filt_d;
    logic [FiltW-1:0] cnt_q [N];
    logic [FiltW-1:0] cnt_d [N];

    // The filtered level only moves after FILT_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s[i] != filt_q[i]) begin
                if (cnt_q[i] == FiltW'(FILT_CYCLES - 1)) begin
                    filt_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign det = filt_q;
`else
    logic unused_filt_cycles;
    assign unused_filt_cycles = ^FILT_CYCLES;
    assign det = s;
`endif

    assign rise       = det & ~prev_q;
    assign fall       = ~det & prev_q;
    assign blank_done = (blank_q == BlankW'(BlankCycles));

    always_comb begin
        prev_d  = det;
        blank_d = blank_done ? blank_q : blank_q + 1'b1;
        for (int i = 0; i < N; i++) begin
            pulse_d[i] = blank_done & ((mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]));
        end
        // A new pulse overrides a simultaneous clear.
        pend_d = (pend_q & ~clr) | pulse_q;
        irq_d  = |pend_q;
        idx_d  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                idx_d = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q  <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            idx_q   <= '0;
            blank_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
        end
    end

    assign pulse = pulse_q;
    assign pend  = pend_q;
    assign irq   = irq_q;
    assign idx   = idx_q;

endmodule

// File: tb/tb_multi_edge_det.sv
// Self-checking bench for multi_edge_det: directed scenarios plus randomized traffic against a
// cycle-indexed delay-line model of the detector.
module tb_multi_edge_det;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int FILT = 4;
`ifdef EDGE_DET_FILTER_EN
    localparam int LAT = SYNC + 1 + FILT;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   sig;
    logic [2*N-1:0] mode;
    logic [N-1:0]   clr;
    logic [N-1:0]   pulse;
    logic [N-1:0]   pend;
    logic           irq;
    logic [4:0]     idx;

    int n_cmp = 0;
    int n_err = 0;

    multi_edge_det #(
        .N          (N),
        .SYNC_STAGES(SYNC),
        .FILT_CYCLES(FILT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sig  (sig),
        .mode (mode),
        .clr  (clr),
        .pulse(pulse),
        .pend (pend),
        .irq  (irq),
        .idx  (idx)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] lowest(input logic [N-1:0] v);
        logic [4:0] r = '0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = 5'(i);
        return r;
    endfunction

    // Holds reset over two rising edges and releases it on a falling edge.
    task automatic do_reset(input logic [N-1:0] level);
        sig = level;
        clr = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sig  = '1;
        mode = '1;
        clr  = '0;
        rst  = 1'b1;
        #3;
        n_cmp++; if (pulse !== '0) begin n_err++; $display("FAIL reset_pulse got %b want 0", pulse); end
        n_cmp++; if (pend !== '0) begin n_err++; $display("FAIL reset_pend got %b want 0", pend); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (idx !== 5'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", idx); end
        @(negedge clk);
    endtask

    task automatic test_rise();
        mode = {N{2'b01}};
        do_reset('0);
        repeat (12) @(negedge clk);
        sig = 4'b0100;
        for (int e = 1; e <= LAT + 2; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (pulse !== ((e == LAT) ? 4'b0100 : 4'b0000)) begin
                n_err++; $display("FAIL rise_pulse edge %0d got %b want %b", e, pulse,
                                  (e == LAT) ? 4'b0100 : 4'b0000);
            end
            if (e == LAT + 1) begin
                n_cmp++; if (pend !== 4'b0100) begin n_err++; $display("FAIL rise_pend got %b want 0100", pend); end
                n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_early got %b want 0", irq); end
            end
            if (e == LAT + 2) begin
                n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rise_irq got %b want 1", irq); end
                n_cmp++; if (idx !== 5'd2) begin n_err++; $display("FAIL rise_idx got %0d want 2", idx); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fall_modes(input logic [1:0] m, input int want);
        int cnt = 0;
        mode = {6'b0, m};
        do_reset(4'b0001);
        repeat (12) @(negedge clk);
        sig = 4'b0000;
        repeat (10) begin @(posedge clk); #1; if (pulse[0]) cnt++; end
        @(negedge clk);
        sig = 4'b0001;
        repeat (10) begin @(posedge clk); #1; if (pulse[0]) cnt++; end
        @(negedge clk);
        n_cmp++;
        if (cnt !== want) begin
            n_err++; $display("FAIL mode_%b_pulse_count got %0d want %0d", m, cnt, want);
        end
    endtask

    task automatic test_clr();
        bit got = 0;
        mode = {2'b01, 2'b01, 2'b01, 2'b11};
        do_reset('0);
        repeat (12) @(negedge clk);
        sig = 4'b0101;
        repeat (LAT + 3) @(negedge clk);
        n_cmp++; if (pend !== 4'b0101) begin n_err++; $display("FAIL clr_setup_pend got %b want 0101", pend); end
        sig = 4'b0100;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (pulse[0]) got = 1;
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL clr_fall_pulse got none want one"); end
        @(negedge clk);
        clr = 4'b0001;
        @(posedge clk); #1;
        n_cmp++; if (pend !== 4'b0101) begin n_err++; $display("FAIL clr_set_wins got %b want 0101", pend); end
        @(negedge clk);
        clr = 4'b0100;
        @(posedge clk); #1;
        n_cmp++; if (pend !== 4'b0001) begin n_err++; $display("FAIL clr_ch2 got %b want 0001", pend); end
        @(negedge clk);
        clr = 4'b0000;
        @(posedge clk); #1;
        n_cmp++; if (idx !== 5'd0) begin n_err++; $display("FAIL clr_idx got %0d want 0", idx); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL clr_irq got %b want 1", irq); end
        @(negedge clk);
    endtask

    task automatic test_hold_high();
        mode = '1;
        do_reset(4'hF);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (pulse !== '0 || pend !== '0) begin
                n_err++; $display("FAIL hold_high edge %0d got pulse=%b pend=%b want 0/0", e, pulse, pend);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_rst_abort();
        mode = {N{2'b01}};
        do_reset('0);
        repeat (12) @(negedge clk);
        sig = 4'b1000;
        repeat (LAT + 4) @(negedge clk);
        n_cmp++; if (irq !== 1'b1 || idx !== 5'd3) begin
            n_err++; $display("FAIL abort_setup got irq=%b idx=%0d want 1/3", irq, idx);
        end
        sig = 4'b1010;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pulse !== '0 || pend !== '0 || irq !== 1'b0 || idx !== 5'd0) begin
            n_err++; $display("FAIL abort_immediate got pulse=%b pend=%b irq=%b idx=%0d want all 0",
                              pulse, pend, irq, idx);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (pulse !== '0 || pend !== '0) begin
                n_err++; $display("FAIL abort_release edge %0d got pulse=%b pend=%b want 0/0", e, pulse, pend);
            end
        end
        @(negedge clk);
    endtask

`ifdef EDGE_DET_FILTER_EN
    task automatic test_glitch();
        int cnt = 0;
        mode = {N{2'b01}};
        do_reset('0);
        repeat (12) @(negedge clk);
        sig = 4'b0001;
        repeat (3) @(negedge clk);
        sig = 4'b0000;
        repeat (15) begin @(posedge clk); #1; if (pulse != '0) cnt++; end
        n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL glitch_pulses got %0d want 0", cnt); end
        @(negedge clk);
        sig = 4'b0001;
        for (int e = 1; e <= LAT + 2; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (pulse !== ((e == LAT) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL filt_pulse edge %0d got %b want %b", e, pulse,
                                  (e == LAT) ? 4'b0001 : 4'b0000);
            end
        end
        @(negedge clk);
    endtask
`endif

    // pat 0: sparse random changes, 1: every channel toggles each cycle, 2: fully random.
    task automatic test_random(input int pat);
        localparam int M = 160;
        logic [N-1:0]   hv [0:M];
        logic [2*N-1:0] mv [0:M];
        logic [N-1:0]   cv [0:M];
        logic [N-1:0]   op [0:M];
        logic [N-1:0]   opd [0:M];
        logic           oirq [0:M];
        logic [4:0]     oidx [0:M];
        logic [N-1:0]   s_af [0:M];
        logic [N-1:0]   d_af [0:M];
        logic [N-1:0]   ep [0:M];
        logic [N-1:0]   epd [0:M];
        logic [2*N-1:0] m0, m1;
        logic [N-1:0]   cur, prv, r, f;
        m0 = 8'($urandom());
        m1 = 8'($urandom());
        hv[0] = '0;
        for (int e = 1; e <= M; e++) begin
            case (pat)
                0:       hv[e] = ($urandom_range(0, 3) == 0) ? hv[e-1] ^ N'($urandom()) : hv[e-1];
                1:       hv[e] = ~hv[e-1];
                default: hv[e] = N'($urandom());
            endcase
            mv[e] = (e < M / 2) ? m0 : m1;
            cv[e] = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '0;
        end

        do_reset('0);
        for (int e = 1; e <= M; e++) begin
            sig  = hv[e];
            mode = mv[e];
            clr  = cv[e];
            @(posedge clk); #1;
            op[e] = pulse; opd[e] = pend; oirq[e] = irq; oidx[e] = idx;
            @(negedge clk);
        end
        clr = '0;

        // Model: level seen by edge logic after edge e, then edges/blanking/pend bookkeeping.
        for (int e = 0; e <= M; e++) begin
            s_af[e] = (e - SYNC + 1 >= 1) ? hv[e-SYNC+1] : '0;
        end
`ifdef EDGE_DET_FILTER_EN
        begin
            logic [N-1:0] lvl = '0;
            int run [N];
            for (int c = 0; c < N; c++) run[c] = 0;
            d_af[0] = '0;
            for (int e = 1; e <= M; e++) begin
                for (int c = 0; c < N; c++) begin
                    if (s_af[e-1][c] != lvl[c]) begin
                        run[c]++;
                        if (run[c] == FILT) begin lvl[c] = s_af[e-1][c]; run[c] = 0; end
                    end else begin
                        run[c] = 0;
                    end
                end
                d_af[e] = lvl;
            end
        end
`else
        for (int e = 0; e <= M; e++) d_af[e] = s_af[e];
`endif
        ep[0] = '0; epd[0] = '0;
        for (int e = 1; e <= M; e++) begin
            cur = d_af[e-1];
            prv = (e >= 2) ? d_af[e-2] : '0;
            r = cur & ~prv;
            f = ~cur & prv;
            for (int c = 0; c < N; c++) begin
                ep[e][c] = (e >= LAT + 1) && ((mv[e][2*c] && r[c]) || (mv[e][2*c+1] && f[c]));
            end
            epd[e] = (epd[e-1] & ~cv[e]) | ep[e-1];
        end

        for (int e = 1; e <= M; e++) begin
            n_cmp++;
            if (op[e] !== ep[e]) begin
                n_err++; $display("FAIL rand%0d_pulse edge %0d got %b want %b", pat, e, op[e], ep[e]);
            end
            n_cmp++;
            if (opd[e] !== epd[e]) begin
                n_err++; $display("FAIL rand%0d_pend edge %0d got %b want %b", pat, e, opd[e], epd[e]);
            end
            n_cmp++;
            if (oirq[e] !== (|epd[e-1])) begin
                n_err++; $display("FAIL rand%0d_irq edge %0d got %b want %b", pat, e, oirq[e], |epd[e-1]);
            end
            n_cmp++;
            if (oidx[e] !== lowest(epd[e-1])) begin
                n_err++; $display("FAIL rand%0d_idx edge %0d got %0d want %0d", pat, e, oidx[e],
                                  lowest(epd[e-1]));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        sig  = '0;
        mode = '0;
        clr  = '0;
        @(negedge clk);
        test_reset();
        test_rise();
        test_fall_modes(2'b10, 1);
        test_fall_modes(2'b11, 2);
        test_fall_modes(2'b01, 1);
        test_clr();
        test_hold_high();
        test_rst_abort();
`ifdef EDGE_DET_FILTER_EN
        test_glitch();
`endif
        test_random(0);
        test_random(1);
        test_random(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
